led7seg_595_scan_driver: RTL and testbench

- Autonomous multiplexed 7-segment scanner driving a chain of 74HC595 shift registers: one digit-select byte plus one segment byte per digit position.
- Holds an internal frame buffer of DIG_NUM segment patterns, written by the host through a simple write port.
- Continuously refreshes every digit in turn: shifts the serial word, latches it, then holds it for a dwell period.
- Adds polarity options and PWM brightness via the 595 OE pin. Sits between clock/calendar logic and the display board pins.

---
 rtl/led7seg_595_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_led7seg_595_scan_driver.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led7seg_595_scan_driver.sv
// Multiplexed 7-segment scanner for a 74HC595 chain: one digit-select byte
// plus one segment byte per refresh, with polarity options and OE-pin PWM.
module led7seg_595_scan_driver #(
  parameter int unsigned DIG_NUM        = 8,
  parameter int unsigned SEG_NUM        = 8,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned DWELL          = 1024,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 0,
  localparam int unsigned AW            = $clog2(DIG_NUM + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         bright,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [SEG_NUM-1:0] wr_data,
  output logic               sclk,
  output logic               rclk,
  output logic               dio,
  output logic               oe_n,
  output logic [AW-1:0]      digit,
  output logic               frame_done
);

  localparam int unsigned W   = DIG_NUM + SEG_NUM;
  localparam int unsigned IW  = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int unsigned CW  = $clog2(2 * CLK_DIV);
  localparam int unsigned BW  = $clog2(W);
  localparam int unsigned DWW = $clog2(DWELL);

  localparam logic [DIG_NUM-1:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [SEG_NUM-1:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_e;

  state_e             state_q;
  logic [SEG_NUM-1:0] fb_q [DIG_NUM];
  logic [W-2:0]       shreg_q;
  logic [CW-1:0]      cnt_q;
  logic [BW-1:0]      bit_q;
  logic [DWW-1:0]     dw_q;
  logic [3:0]         pwm_q;
  logic [AW-1:0]      digit_q;
  logic               sclk_q;
  logic               rclk_q;
  logic               dio_q;
  logic               oe_n_q;
  logic               frame_done_q;

  logic [DIG_NUM-1:0] dsel_c;
  logic [W-1:0]       word_c;
  logic               last_dig_c;

  // Serial word for the digit about to be loaded: {digit select, segments}
  always_comb begin
    dsel_c     = {{(DIG_NUM-1){1'b0}}, 1'b1} << digit_q;
    word_c     = {dsel_c ^ DIG_XOR, fb_q[digit_q[IW-1:0]] ^ SEG_XOR};
    last_dig_c = (digit_q == AW'(DIG_NUM - 1));
  end

  // Frame buffer: host writes, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIG_NUM; i++) begin
        fb_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr < AW'(DIG_NUM))) begin
      fb_q[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // Scan FSM: load, shift out, latch, then dwell with PWM on OE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
      dw_q         <= '0;
      pwm_q        <= '0;
      digit_q      <= '0;
      sclk_q       <= 1'b0;
      rclk_q       <= 1'b0;
      dio_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sclk_q <= 1'b0;
          rclk_q <= 1'b0;
          dio_q  <= 1'b0;
          oe_n_q <= 1'b1;
          if (en) state_q <= S_LOAD;
        end
        S_LOAD: begin
          // dio carries the MSB directly; shreg_q holds the bits still to go
          shreg_q <= word_c[W-2:0];
          dio_q   <= word_c[W-1];
          bit_q   <= '0;
          cnt_q   <= '0;
          sclk_q  <= 1'b0;
          oe_n_q  <= 1'b1;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            shreg_q <= {shreg_q[W-3:0], 1'b0};
            if (bit_q == BW'(W - 1)) begin
              dio_q   <= 1'b0;
              rclk_q  <= 1'b1;
              state_q <= S_LATCH;
            end else begin
              bit_q <= bit_q + BW'(1);
              dio_q <= shreg_q[W-2];
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            sclk_q <= ((cnt_q + CW'(1)) >= CW'(CLK_DIV));
          end
        end
        S_LATCH: begin
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_q   <= '0;
            rclk_q  <= 1'b0;
            dw_q    <= '0;
            pwm_q   <= '0;
            oe_n_q  <= (bright == 4'd0);
            state_q <= S_DWELL;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DWELL: begin
          if (dw_q == DWW'(DWELL - 1)) begin
            oe_n_q  <= 1'b1;
            digit_q <= last_dig_c ? '0 : digit_q + AW'(1);
            state_q <= en ? S_LOAD : S_IDLE;
          end else begin
            dw_q   <= dw_q + DWW'(1);
            pwm_q  <= pwm_q + 4'd1;
            oe_n_q <= !((pwm_q + 4'd1) < bright);
            // Registered so the pulse lands on the final dwell cycle
            if (dw_q == DWW'(DWELL - 2)) frame_done_q <= last_dig_c;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sclk       = sclk_q;
  assign rclk       = rclk_q;
  assign dio        = dio_q;
  assign oe_n       = oe_n_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_595_scan_driver.sv
// Self-checking bench for led7seg_595_scan_driver (normal and inverted polarity).
module tb_led7seg_595_scan_driver;

  localparam int unsigned DN = 4;
  localparam int unsigned SN = 8;
  localparam int unsigned CD = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = DN + SN;
  localparam int unsigned AW = 3;
  localparam int DIGIT_PERIOD = 1 + 2 * W * CD + CD + DW;
  localparam int FRAME_PERIOD = DN * DIGIT_PERIOD;
  localparam int REC_LIMIT    = DIGIT_PERIOD + 50;

  typedef struct {
    int           dig;
    logic [W-1:0] bits;
    int           nsclk;
    int           cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst, en, wr_en;
  logic [3:0]    bright;
  logic [AW-1:0] wr_addr;
  logic [SN-1:0] wr_data;

  logic          sclk, rclk, dio, oe_n, frame_done;
  logic [AW-1:0] digit;
  logic          sclk_p, rclk_p, dio_p, oe_n_p, frame_done_p;
  logic [AW-1:0] digit_p;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [SN-1:0] m_fb [DN];
  rec_t q_main[$];
  rec_t q_pol[$];
  int   fd_q[$];
  int   fd_dq[$];
  int   overlap = 0;
  int   fd_wide = 0;
  int   lockstep_err = 0;

  always #5 clk = ~clk;

  led7seg_595_scan_driver #(
    .DIG_NUM(DN), .SEG_NUM(SN), .CLK_DIV(CD), .DWELL(DW),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .bright(bright), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sclk(sclk), .rclk(rclk),
    .dio(dio), .oe_n(oe_n), .digit(digit), .frame_done(frame_done)
  );

  led7seg_595_scan_driver #(
    .DIG_NUM(DN), .SEG_NUM(SN), .CLK_DIV(CD), .DWELL(DW),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_pol (
    .clk(clk), .rst(rst), .en(en), .bright(bright), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sclk(sclk_p), .rclk(rclk_p),
    .dio(dio_p), .oe_n(oe_n_p), .digit(digit_p), .frame_done(frame_done_p)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference word: one-hot digit select over the logical segment pattern
  function automatic logic [W-1:0] exp_word(input int d, input bit pol);
    logic [DN-1:0] sel;
    logic [SN-1:0] seg;
    sel = '0;
    seg = '0;
    if (d >= 0 && d < int'(DN)) begin
      sel[d] = 1'b1;
      seg    = m_fb[d];
    end
    if (pol) begin
      sel = ~sel;
      seg = ~seg;
    end
    return {sel, seg};
  endfunction

  // Wire-level monitor: deserialise on sclk rise, record one word per rclk rise
  logic [W-1:0] acc_m = '0, acc_p = '0;
  int ns_m = 0, ns_p = 0;
  logic sp_m = 1'b0, rp_m = 1'b0, sp_p = 1'b0, rp_p = 1'b0, fd_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      acc_m = '0; ns_m = 0; acc_p = '0; ns_p = 0;
    end else begin
      if (sclk && !sp_m) begin acc_m = {acc_m[W-2:0], dio}; ns_m++; end
      if (rclk && !rp_m) begin
        q_main.push_back('{int'(digit), acc_m, ns_m, cyc});
        acc_m = '0; ns_m = 0;
      end
      if (sclk_p && !sp_p) begin acc_p = {acc_p[W-2:0], dio_p}; ns_p++; end
      if (rclk_p && !rp_p) begin
        q_pol.push_back('{int'(digit_p), acc_p, ns_p, cyc});
        acc_p = '0; ns_p = 0;
      end
      if ((rclk && sclk) || (rclk_p && sclk_p)) overlap++;
      if (frame_done) begin
        if (fd_prev) fd_wide++;
        else begin fd_q.push_back(cyc); fd_dq.push_back(int'(digit)); end
      end
      if (sclk_p !== sclk || rclk_p !== rclk || oe_n_p !== oe_n ||
          digit_p !== digit || frame_done_p !== frame_done) lockstep_err++;
    end
    sp_m = sclk; rp_m = rclk; sp_p = sclk_p; rp_p = rclk_p; fd_prev = frame_done;
  end

  task automatic drive_write(input logic [AW-1:0] a, input logic [SN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (int'(a) < int'(DN)) m_fb[a[1:0]] = d;
  endtask

  task automatic pop_main(output rec_t r, output bit ok);
    int t = 0;
    while (q_main.size() == 0 && t < REC_LIMIT) begin @(negedge clk); t++; end
    ok = (q_main.size() != 0);
    r  = '{-1, '0, 0, 0};
    if (ok) r = q_main.pop_front();
  endtask

  task automatic pop_pol(output rec_t r, output bit ok);
    int t = 0;
    while (q_pol.size() == 0 && t < REC_LIMIT) begin @(negedge clk); t++; end
    ok = (q_pol.size() != 0);
    r  = '{-1, '0, 0, 0};
    if (ok) r = q_pol.pop_front();
  endtask

  task automatic test_reset();
    int t;
    int viol;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; bright = 4'd15;
    repeat (3) @(negedge clk);
    n_total++;
    if ({sclk, rclk, dio, oe_n, frame_done} !== 5'b00010 || digit !== 3'd0)
      $display("FAIL reset_init: sclk=%b rclk=%b dio=%b oe_n=%b fd=%b digit=%0d, want 0 0 0 1 0 0",
               sclk, rclk, dio, oe_n, frame_done, digit);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < int'(DN); i++) drive_write(AW'(i), SN'($urandom));
    en = 1'b1;
    t = 0;
    while (!(digit == 3'd1 && sclk) && t < 2 * DIGIT_PERIOD) begin @(negedge clk); t++; end
    n_total++;
    if (!(digit == 3'd1 && sclk)) $display("FAIL reset_reach_shift: digit=%0d sclk=%b, want 1 1", digit, sclk);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({sclk, rclk, dio, oe_n, frame_done} !== 5'b00010 || digit !== 3'd0)
      $display("FAIL reset_midshift: sclk=%b rclk=%b dio=%b oe_n=%b fd=%b digit=%0d, want 0 0 0 1 0 0",
               sclk, rclk, dio, oe_n, frame_done, digit);
    else n_pass++;
    for (int i = 0; i < int'(DN); i++) m_fb[i] = '0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk || rclk || dio || !oe_n || digit != 3'd0) viol++;
    end
    n_total++;
    if (viol != 0) $display("FAIL reset_idle: %0d active cycles, want 0", viol);
    else n_pass++;
  endtask

  task automatic test_pattern();
    rec_t r;
    bit   ok;
    int   prev_cyc;
    drive_write(3'd0, 8'h3F);
    drive_write(3'd1, 8'hA5);
    bright = 4'd15;
    q_main.delete(); q_pol.delete();
    en = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      pop_main(r, ok);
      n_total++;
      if (!ok || r.dig != (k % int'(DN)) || r.bits !== exp_word(k % int'(DN), 1'b0) || r.nsclk != int'(W))
        $display("FAIL pattern_rec%0d: ok=%0d dig=%0d bits=%b edges=%0d, want dig=%0d bits=%b edges=%0d",
                 k, ok, r.dig, r.bits, r.nsclk, k % int'(DN), exp_word(k % int'(DN), 1'b0), W);
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if (r.bits !== 12'b0010_10100101) $display("FAIL pattern_digit1_literal: bits=%b, want 001010100101", r.bits);
        else n_pass++;
      end
      if (k > 0) begin
        n_total++;
        if (r.cyc - prev_cyc != DIGIT_PERIOD)
          $display("FAIL pattern_period%0d: %0d cycles, want %0d", k, r.cyc - prev_cyc, DIGIT_PERIOD);
        else n_pass++;
      end
      prev_cyc = r.cyc;
    end
    n_total++;
    if (overlap != 0) $display("FAIL rclk_sclk_overlap: %0d cycles, want 0", overlap);
    else n_pass++;
  endtask

  task automatic test_brightness();
    int   b;
    int   t;
    int   viol;
    logic prev;
    logic want;
    for (int s = 0; s < 3; s++) begin
      b = (s == 0) ? 4 : (s == 1) ? 0 : int'($urandom_range(1, 15));
      bright = 4'(b);
      prev = rclk; t = 0;
      while (t < 2 * DIGIT_PERIOD) begin
        @(negedge clk); t++;
        if (prev && !rclk) break;
        prev = rclk;
      end
      viol = 0;
      for (int i = 0; i < int'(DW); i++) begin
        want = !((i % 16) < b);
        if (oe_n !== want) viol++;
        @(negedge clk);
      end
      if (oe_n !== 1'b1) viol++;
      n_total++;
      if (t >= 2 * DIGIT_PERIOD || viol != 0)
        $display("FAIL brightness_%0d: %0d wrong oe_n cycles (timeout=%0d), want 0", b, viol, t >= 2 * DIGIT_PERIOD);
      else n_pass++;
    end
    bright = 4'd15;
  endtask

  task automatic test_polarity();
    rec_t r;
    rec_t rp;
    bit   ok;
    bit   okp;
    int   t;
    bit   seen2;
    t = 0;
    while (digit != 3'd0 && t < FRAME_PERIOD) begin @(negedge clk); t++; end
    drive_write(3'd2, 8'h00);
    drive_write(3'd3, SN'($urandom));
    q_main.delete(); q_pol.delete();
    seen2 = 1'b0;
    for (int k = 0; k < int'(DN); k++) begin
      pop_main(r, ok);
      pop_pol(rp, okp);
      n_total++;
      if (!ok || !okp || r.bits !== exp_word(r.dig, 1'b0) || rp.bits !== exp_word(rp.dig, 1'b1) || rp.dig != r.dig)
        $display("FAIL polarity_rec%0d: dig=%0d/%0d bits=%b/%b, want %b/%b",
                 k, r.dig, rp.dig, r.bits, rp.bits, exp_word(r.dig, 1'b0), exp_word(rp.dig, 1'b1));
      else n_pass++;
      if (okp && rp.dig == 2) begin
        seen2 = 1'b1;
        n_total++;
        if (rp.bits !== 12'b1011_11111111) $display("FAIL polarity_digit2: bits=%b, want 101111111111", rp.bits);
        else n_pass++;
      end
    end
    n_total++;
    if (!seen2) $display("FAIL polarity_seen2: digit 2 word not observed, want observed");
    else n_pass++;
  endtask

  task automatic test_scan_control();
    rec_t r;
    bit   ok;
    int   t;
    int   t_change;
    int   viol;
    fd_q.delete(); fd_dq.delete(); fd_wide = 0;
    t = 0;
    while (fd_q.size() < 3 && t < 3 * FRAME_PERIOD + 200) begin @(negedge clk); t++; end
    n_total++;
    if (fd_q.size() < 3) $display("FAIL frame_done_count: %0d pulses, want 3", fd_q.size());
    else begin
      n_pass++;
      n_total++;
      if (fd_q[1] - fd_q[0] != FRAME_PERIOD || fd_q[2] - fd_q[1] != FRAME_PERIOD)
        $display("FAIL frame_done_period: %0d/%0d, want %0d", fd_q[1] - fd_q[0], fd_q[2] - fd_q[1], FRAME_PERIOD);
      else n_pass++;
      n_total++;
      if (fd_dq[0] != int'(DN) - 1 || fd_dq[1] != int'(DN) - 1 || fd_wide != 0)
        $display("FAIL frame_done_shape: digit=%0d wide=%0d, want %0d 0", fd_dq[0], fd_wide, DN - 1);
      else n_pass++;
    end
    // Drop en during digit 1's shift
    t = 0;
    while (!(digit == 3'd1 && sclk) && t < 2 * FRAME_PERIOD) begin @(negedge clk); t++; end
    en = 1'b0;
    q_main.delete();
    t = 0;
    while (digit != 3'd2 && t < 300) begin @(negedge clk); t++; end
    t_change = cyc;
    pop_main(r, ok);
    n_total++;
    if (!ok || r.dig != 1 || r.bits !== exp_word(1, 1'b0) || t_change - r.cyc != int'(CD + DW))
      $display("FAIL en_drop_finish: dig=%0d bits=%b latch_to_idle=%0d, want 1 %b %0d",
               r.dig, r.bits, t_change - r.cyc, exp_word(1, 1'b0), CD + DW);
    else n_pass++;
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (sclk || rclk || !oe_n || digit != 3'd2) viol++;
    end
    n_total++;
    if (viol != 0 || q_main.size() != 0)
      $display("FAIL en_drop_idle: %0d active cycles, %0d words, want 0 0", viol, q_main.size());
    else n_pass++;
    en = 1'b1;
    pop_main(r, ok);
    n_total++;
    if (!ok || r.dig != 2 || r.bits !== exp_word(2, 1'b0))
      $display("FAIL en_resume: dig=%0d bits=%b, want 2 %b", r.dig, r.bits, exp_word(2, 1'b0));
    else n_pass++;
  endtask

  task automatic test_collision();
    rec_t          r;
    bit            ok;
    int            t;
    int            target;
    logic [AW-1:0] prev;
    logic [SN-1:0] newv;
    logic [W-1:0]  old_word;
    target = int'($urandom_range(0, DN - 1));
    prev = digit; t = 0;
    while (t < FRAME_PERIOD + 100) begin
      @(negedge clk); t++;
      if (int'(digit) == target && int'(prev) != target) break;
      prev = digit;
    end
    n_total++;
    if (t >= FRAME_PERIOD + 100) $display("FAIL collision_find_load: digit %0d load not seen, want seen", target);
    else n_pass++;
    old_word = exp_word(target, 1'b0);
    newv = m_fb[target] ^ SN'($urandom_range(1, 255));
    wr_en = 1'b1; wr_addr = AW'(target); wr_data = newv;
    q_main.delete();
    @(negedge clk);
    wr_en = 1'b0;
    pop_main(r, ok);
    n_total++;
    if (!ok || r.dig != target || r.bits !== old_word)
      $display("FAIL collision_old: dig=%0d bits=%b, want %0d %b", r.dig, r.bits, target, old_word);
    else n_pass++;
    m_fb[target] = newv;
    drive_write(3'd5, SN'($urandom));
    for (int k = 1; k <= int'(DN); k++) begin
      pop_main(r, ok);
      n_total++;
      if (!ok || r.dig != (target + k) % int'(DN) || r.bits !== exp_word((target + k) % int'(DN), 1'b0))
        $display("FAIL collision_next%0d: dig=%0d bits=%b, want %0d %b", k, r.dig, r.bits,
                 (target + k) % int'(DN), exp_word((target + k) % int'(DN), 1'b0));
      else n_pass++;
    end
    n_total++;
    if (overlap != 0 || lockstep_err != 0)
      $display("FAIL timing_invariants: overlap=%0d lockstep=%0d, want 0 0", overlap, lockstep_err);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern();
    test_brightness();
    test_polarity();
    test_scan_control();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
